// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester's byte at a time to a UART transmitter.
// Build option: define UART_TX_ARB_PARITY_CFG_EN to add per-requester parity enable/type inputs.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8,
  parameter int TIMEOUT   = 3
) (
  input  logic                           CLK,
  input  logic                           RST_ASYN,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   REQ_DATA,
`ifdef UART_TX_ARB_PARITY_CFG_EN
  input  logic [NUM_REQ-1:0]             PAR_EN_CFG,
  input  logic [NUM_REQ-1:0]             PAR_TYP_CFG,
`endif
  output logic [NUM_REQ-1:0]             GNT,
  output logic [DATAWIDTH-1:0]           TX_P_DATA,
  output logic                           TX_Data_Valid,
  output logic                           TX_PAR_EN,
  output logic                           TX_PAR_TYP,
  input  logic                           TX_busy,
  input  logic                           ERR_CLR,
  output logic                           ARB_BUSY,
  output logic                           ERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     last_winner;
  logic [IDX_W-1:0]     winner;
  logic                 winner_found;
  logic                 grant;
  logic                 timeout_hit;
  logic [CNT_W-1:0]     wait_cnt;
  logic [DATAWIDTH-1:0] win_data;

  // Search upward from the requester after the previous winner, wrapping to 0.
  always_comb begin : rr_search
    int idx;
    idx          = 0;
    winner       = last_winner;
    winner_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_winner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!winner_found && REQ[IDX_W'(idx)]) begin
        winner       = IDX_W'(idx);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin : data_mux
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) win_data = REQ_DATA[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) state <= IDLE;
    else           state <= state_nxt;
  end

  // ISSUE is a single cycle, so a requester still holding REQ during its GNT cannot win twice.
  always_comb begin : fsm_next
    state_nxt   = state;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (winner_found && !TX_busy) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (TX_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!TX_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : gnt_decode
    GNT = '0;
    if (state == ISSUE) GNT[last_winner] = 1'b1;
  end

  assign TX_Data_Valid = (state == ISSUE);
  assign ARB_BUSY      = (state != IDLE);

  // A timeout set in the same cycle as ERR_CLR takes priority so no error is lost.
  always_ff @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) begin
      last_winner <= LAST_IDX;
      TX_P_DATA   <= '0;
      wait_cnt    <= '0;
      ERR         <= 1'b0;
    end else begin
      if (grant) begin
        last_winner <= winner;
        TX_P_DATA   <= win_data;
      end
      if (state == WAIT_BUSY) wait_cnt <= wait_cnt + CNT_W'(1);
      else                    wait_cnt <= '0;
      if (timeout_hit)  ERR <= 1'b1;
      else if (ERR_CLR) ERR <= 1'b0;
    end
  end

`ifdef UART_TX_ARB_PARITY_CFG_EN
  always_ff @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) begin
      TX_PAR_EN  <= 1'b0;
      TX_PAR_TYP <= 1'b0;
    end else if (grant) begin
      TX_PAR_EN  <= PAR_EN_CFG[winner];
      TX_PAR_TYP <= PAR_TYP_CFG[winner];
    end
  end
`else
  assign TX_PAR_EN  = 1'b0;
  assign TX_PAR_TYP = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART transmitter model (10-cycle frames).
// Parity checks follow UART_TX_ARB_PARITY_CFG_EN when it is defined for the build.
module tb_uart_tx_arbiter;

  localparam int TIMEOUT = 3;

  logic        CLK = 1'b0;
  logic        RST_ASYN;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
`ifdef UART_TX_ARB_PARITY_CFG_EN
  logic [3:0]  PAR_EN_CFG;
  logic [3:0]  PAR_TYP_CFG;
`endif
  logic [3:0]  GNT;
  logic [7:0]  TX_P_DATA;
  logic        TX_Data_Valid;
  logic        TX_PAR_EN;
  logic        TX_PAR_TYP;
  logic        TX_busy;
  logic        ERR_CLR;
  logic        ARB_BUSY;
  logic        ERR;

  logic        model_en;
  logic        ext_busy;
  int          busy_left;
  logic        line_par;
  logic        line_par_en;
  logic        busy_at_edge;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATAWIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .CLK          (CLK),
    .RST_ASYN     (RST_ASYN),
    .REQ          (REQ),
    .REQ_DATA     (REQ_DATA),
`ifdef UART_TX_ARB_PARITY_CFG_EN
    .PAR_EN_CFG   (PAR_EN_CFG),
    .PAR_TYP_CFG  (PAR_TYP_CFG),
`endif
    .GNT          (GNT),
    .TX_P_DATA    (TX_P_DATA),
    .TX_Data_Valid(TX_Data_Valid),
    .TX_PAR_EN    (TX_PAR_EN),
    .TX_PAR_TYP   (TX_PAR_TYP),
    .TX_busy      (TX_busy),
    .ERR_CLR      (ERR_CLR),
    .ARB_BUSY     (ARB_BUSY),
    .ERR          (ERR)
  );

  always #5 CLK = ~CLK;

  // Transmitter: busy the cycle after the strobe, for 10 cycles; records the parity bit it sends.
  always @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) begin
      busy_left   <= 0;
      line_par    <= 1'b0;
      line_par_en <= 1'b0;
    end else if (model_en && TX_Data_Valid) begin
      busy_left   <= 10;
      line_par    <= TX_PAR_TYP ? ~^TX_P_DATA : ^TX_P_DATA;
      line_par_en <= TX_PAR_EN;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end
  end

  assign TX_busy = (busy_left != 0) || ext_busy;

  always @(posedge CLK) busy_at_edge <= TX_busy;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Any grant must be one-hot, coincide with the strobe, and follow an idle transmitter.
  always @(negedge CLK) begin
    if (GNT != 4'b0000) begin
      check_output("gnt_onehot", 32'($onehot(GNT)), 32'd1);
      check_output("gnt_with_valid", 32'(TX_Data_Valid), 32'd1);
      check_output("gnt_busy_idle", 32'(busy_at_edge), 32'd0);
    end
  end

  task automatic apply_stimulus(input logic [3:0] req, input logic [31:0] data);
    REQ      = req;
    REQ_DATA = data;
  endtask

  task automatic reset_dut();
    RST_ASYN = 1'b0;
    repeat (2) @(negedge CLK);
    RST_ASYN = 1'b1;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (ARB_BUSY && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    check_output("idle_wait_bound", 32'(cyc < 40), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl[9];

  initial begin : main
    int cyc;
    tbl[0] = '{4'b0001, 32'h443322D9, 4'b0001, 8'hD9};
    tbl[1] = '{4'b1111, 32'h44332211, 4'b0010, 8'h22};
    tbl[2] = '{4'b1111, 32'h44332211, 4'b0100, 8'h33};
    tbl[3] = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
    tbl[4] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
    tbl[5] = '{4'b1001, 32'h44332211, 4'b1000, 8'h44};
    tbl[6] = '{4'b0110, 32'h44332211, 4'b0010, 8'h22};
    tbl[7] = '{4'b0101, 32'h44332211, 4'b0100, 8'h33};
    tbl[8] = '{4'b0011, 32'h44332211, 4'b0001, 8'h11};

    model_en = 1'b1;
    ext_busy = 1'b0;
    ERR_CLR  = 1'b0;
`ifdef UART_TX_ARB_PARITY_CFG_EN
    PAR_EN_CFG  = 4'b0000;
    PAR_TYP_CFG = 4'b0000;
`endif
    apply_stimulus(4'b0000, 32'h0);
    RST_ASYN = 1'b0;
    #1;
    check_output("rst_gnt", 32'(GNT), 32'h0);
    check_output("rst_valid", 32'(TX_Data_Valid), 32'h0);
    check_output("rst_arb_busy", 32'(ARB_BUSY), 32'h0);
    check_output("rst_err", 32'(ERR), 32'h0);
    check_output("rst_data", 32'(TX_P_DATA), 32'h0);
    repeat (2) @(negedge CLK);
    RST_ASYN = 1'b1;

    // Round-robin table: each frame runs to completion, next REQ applied during the grant cycle.
    apply_stimulus(tbl[0].req, tbl[0].data);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (GNT == 4'b0000 && cyc < 20);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge CLK);
      check_output($sformatf("v%0d_gnt", i), 32'(GNT), 32'(tbl[i].exp_gnt));
      check_output($sformatf("v%0d_data", i), 32'(TX_P_DATA), 32'(tbl[i].exp_data));
      check_output($sformatf("v%0d_valid", i), 32'(TX_Data_Valid), 32'd1);
      check_output($sformatf("v%0d_par", i), 32'({TX_PAR_EN, TX_PAR_TYP}), 32'd0);
      if (i < 8) apply_stimulus(tbl[i+1].req, tbl[i+1].data);
      else       apply_stimulus(4'b0000, tbl[i].data);
      @(negedge CLK);
      check_output($sformatf("v%0d_gnt_pulse", i), 32'(GNT), 32'h0);
      check_output($sformatf("v%0d_valid_pulse", i), 32'(TX_Data_Valid), 32'd0);
      check_output($sformatf("v%0d_arb_busy_wb", i), 32'(ARB_BUSY), 32'd1);
      check_output($sformatf("v%0d_data_hold", i), 32'(TX_P_DATA), 32'(tbl[i].exp_data));
      cyc = 0;
      while (TX_busy && cyc < 20) begin
        @(negedge CLK);
        check_output($sformatf("v%0d_no_gnt_busy", i), 32'(GNT), 32'h0);
        cyc++;
      end
      check_output($sformatf("v%0d_busy_bound", i), 32'(cyc < 20), 32'd1);
      check_output($sformatf("v%0d_arb_busy_fall", i), 32'(ARB_BUSY), 32'd1);
      @(negedge CLK);
      check_output($sformatf("v%0d_idle", i), 32'(ARB_BUSY), 32'd0);
      check_output($sformatf("v%0d_idle_gnt", i), 32'(GNT), 32'h0);
    end

    // Timeout: transmitter never raises busy; last winner is 0 so requester 1 wins next.
    model_en = 1'b0;
    apply_stimulus(4'b0010, 32'h44332211);
    @(negedge CLK);
    check_output("to_gnt", 32'(GNT), 32'h2);
    apply_stimulus(4'b0000, 32'h44332211);
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge CLK);
      check_output($sformatf("to_err_low_%0d", c), 32'(ERR), 32'd0);
      check_output($sformatf("to_arb_busy_%0d", c), 32'(ARB_BUSY), 32'd1);
    end
    @(negedge CLK);
    check_output("to_err_set", 32'(ERR), 32'd1);
    check_output("to_idle", 32'(ARB_BUSY), 32'd0);
    repeat (2) @(negedge CLK);
    check_output("to_err_sticky", 32'(ERR), 32'd1);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    check_output("to_err_clr", 32'(ERR), 32'd0);

    // Set and clear together: ERR_CLR held through the whole second timeout.
    apply_stimulus(4'b0100, 32'h44332211);
    @(negedge CLK);
    check_output("to2_gnt", 32'(GNT), 32'h4);
    apply_stimulus(4'b0000, 32'h44332211);
    repeat (TIMEOUT) @(negedge CLK);
    check_output("to2_err_pre", 32'(ERR), 32'd0);
    @(negedge CLK);
    check_output("to2_set_wins", 32'(ERR), 32'd1);
    ERR_CLR = 1'b0;
    @(negedge CLK);
    check_output("to2_err_hold", 32'(ERR), 32'd1);

    // Reset pulse in WAIT_DONE with ERR set and data latched.
    model_en = 1'b1;
    apply_stimulus(4'b1000, 32'h44332211);
    @(negedge CLK);
    check_output("rw_gnt", 32'(GNT), 32'h8);
    apply_stimulus(4'b0000, 32'h44332211);
    repeat (3) @(negedge CLK);
    check_output("rw_in_frame", 32'({ARB_BUSY, TX_busy}), 32'h3);
    #2;
    RST_ASYN = 1'b0;
    #1;
    check_output("rw_gnt0", 32'(GNT), 32'h0);
    check_output("rw_data0", 32'(TX_P_DATA), 32'h0);
    check_output("rw_valid0", 32'(TX_Data_Valid), 32'd0);
    check_output("rw_arb_busy0", 32'(ARB_BUSY), 32'd0);
    check_output("rw_err0", 32'(ERR), 32'd0);
    check_output("rw_par0", 32'({TX_PAR_EN, TX_PAR_TYP}), 32'd0);
    apply_stimulus(4'b1111, 32'h44332211);
    @(negedge CLK);
    check_output("rw_no_gnt_in_rst", 32'(GNT), 32'h0);
    @(negedge CLK);
    RST_ASYN = 1'b1;
    check_output("rw_no_gnt_release", 32'({GNT, TX_Data_Valid}), 32'h0);
    @(negedge CLK);
    check_output("rw_first_gnt", 32'(GNT), 32'h1);
    check_output("rw_first_data", 32'(TX_P_DATA), 32'h11);
    apply_stimulus(4'b0000, 32'h44332211);
    @(negedge CLK);
    wait_idle();

    // External busy blocks the grant until it falls.
    reset_dut();
    ext_busy = 1'b1;
    apply_stimulus(4'b0100, 32'h005AD900);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check_output($sformatf("xb_no_gnt_%0d", c), 32'({GNT, ARB_BUSY}), 32'h0);
    end
    ext_busy = 1'b0;
    @(negedge CLK);
    check_output("xb_gnt", 32'(GNT), 32'h4);
    check_output("xb_data", 32'(TX_P_DATA), 32'h5A);
    apply_stimulus(4'b0000, 32'h005AD900);
    @(negedge CLK);
    wait_idle();

    // Parity: requester 1 configured for odd parity, byte 0xD9.
`ifdef UART_TX_ARB_PARITY_CFG_EN
    PAR_EN_CFG  = 4'b0010;
    PAR_TYP_CFG = 4'b0010;
`endif
    apply_stimulus(4'b0010, 32'h005AD900);
    @(negedge CLK);
    check_output("par_gnt", 32'(GNT), 32'h2);
    check_output("par_data", 32'(TX_P_DATA), 32'hD9);
    apply_stimulus(4'b0000, 32'h0);
    @(negedge CLK);
`ifdef UART_TX_ARB_PARITY_CFG_EN
    check_output("par_en", 32'(TX_PAR_EN), 32'd1);
    check_output("par_typ", 32'(TX_PAR_TYP), 32'd1);
    check_output("par_line_en", 32'(line_par_en), 32'd1);
    check_output("par_line_bit", 32'(line_par), 32'd0);
`else
    check_output("par_en_off", 32'(TX_PAR_EN), 32'd0);
    check_output("par_typ_off", 32'(TX_PAR_TYP), 32'd0);
    check_output("par_line_en_off", 32'(line_par_en), 32'd0);
`endif
    wait_idle();
    check_output("par_data_hold", 32'(TX_P_DATA), 32'hD9);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, default 4: number of requesters.
- DATAWIDTH, default 8: byte width.
- TIMEOUT, default 3: maximum cycles to wait for TX_busy to rise.

REQ-002 The block SHALL have these ports:
- CLK  in  1  system clock, rising edge.
- RST_ASYN  in  1  asynchronous, active-low reset.
- REQ  in  NUM_REQ  per-requester send request, level.
- REQ_DATA  in  NUM_REQ*DATAWIDTH  byte of requester i at [DATAWIDTH*i +: DATAWIDTH].
- GNT  out  NUM_REQ  one-hot, one-cycle accept pulse.
- TX_P_DATA  out  DATAWIDTH  byte to the UART transmitter.
- TX_Data_Valid  out  1  one-cycle load strobe to the transmitter.
- TX_PAR_EN  out  1  parity enable to the transmitter.
- TX_PAR_TYP  out  1  parity type to the transmitter (0 even, 1 odd).
- TX_busy  in  1  transmitter busy flag.
- ERR_CLR  in  1  clears ERR.
- ARB_BUSY  out  1  high whenever state is not IDLE.
- ERR  out  1  sticky timeout flag.

REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, with the clock named CLK and the reset named RST_ASYN.

Function
REQ-004 The state machine SHALL have four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE, all registered.
REQ-005 IDLE SHALL take a grant only when REQ is non-zero and TX_busy is 0; otherwise it stays in IDLE.
REQ-006 The winner SHALL be selected round-robin, searching upward from last_winner+1 with wrap at NUM_REQ-1 to 0.
REQ-007 On a grant at the edge closing cycle N, during cycle N+1 the block SHALL:
- drive GNT[winner]=1 (one cycle);
- drive TX_Data_Valid=1 (one cycle);
- drive TX_P_DATA with the byte latched from REQ_DATA at cycle N;
- be in state ISSUE;
- update last_winner to the winner.
REQ-008 ISSUE SHALL last exactly one cycle, then go to WAIT_BUSY.
REQ-009 WAIT_BUSY SHALL go to WAIT_DONE when TX_busy=1.
REQ-010 If TX_busy is still 0 after TIMEOUT cycles in WAIT_BUSY, the block SHALL set ERR=1 and return to IDLE.
REQ-011 WAIT_DONE SHALL return to IDLE on the first cycle TX_busy=0; the earliest next grant is therefore one cycle after busy falls.
REQ-012 TX_P_DATA, TX_PAR_EN and TX_PAR_TYP SHALL hold their latched values until the next grant.
REQ-013 Requester handshake:
- A requester SHALL hold REQ and its data stable until it sees GNT.
- REQ still high during the GNT cycle SHALL NOT produce a second grant, because that cycle is ISSUE.
- REQ dropped before a grant SHALL be ignored, with no grant and no state change.
REQ-014 When ERR is being set and ERR_CLR=1 in the same cycle, set SHALL win; otherwise ERR_CLR=1 SHALL clear ERR on the next edge.
REQ-015 GNT SHALL never have more than one bit set, and SHALL be all-zero outside ISSUE.

Reset
REQ-016 While RST_ASYN=0, the block SHALL immediately drive GNT, TX_P_DATA, TX_Data_Valid, TX_PAR_EN, TX_PAR_TYP, ARB_BUSY and ERR to 0, with state IDLE and last_winner=NUM_REQ-1, so requester 0 wins first.
REQ-017 Reset asserted in any state SHALL abort the transaction, with no grant or strobe on release; the first grant SHALL NOT occur before the first rising edge after release.

Configuration
REQ-018 The macro UART_TX_ARB_PARITY_CFG_EN SHALL control per-requester parity, as follows.
REQ-019 With the macro defined:
- The block SHALL add inputs PAR_EN_CFG[NUM_REQ-1:0] and PAR_TYP_CFG[NUM_REQ-1:0].
- The winner's bits SHALL be latched into TX_PAR_EN and TX_PAR_TYP at grant, alongside the data.
REQ-020 With the macro undefined:
- The PAR_EN_CFG and PAR_TYP_CFG ports SHALL be absent.
- TX_PAR_EN and TX_PAR_TYP SHALL be constant 0.

Verification
REQ-021 The bench SHALL cover these directed scenarios, using a UART transmitter model (busy high the cycle after strobe, 10 bit-times long):
- Reset then REQ=0001, byte0=0xD9 -> GNT=0001 for one cycle; TX_Data_Valid one cycle; TX_P_DATA=0xD9; ARB_BUSY stays high until busy falls.
- REQ=1111 held, bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0; exactly one grant per frame; no grant while TX_busy=1.
- TX_busy stuck 0 after strobe -> ERR=1 exactly TIMEOUT cycles after WAIT_BUSY entry, state IDLE; then ERR_CLR=1 -> ERR=0; simultaneous set and clear -> ERR=1.
- TX_busy=1 externally while REQ=0100 -> no GNT; grant on the edge after busy falls, with GNT=0100.
- RST_ASYN=0 pulsed mid-WAIT_DONE -> all outputs 0 immediately; REQ=1111 after release -> requester 0 granted first.
- Macro defined, PAR_EN_CFG=0010, PAR_TYP_CFG=0010, REQ=0010, byte1=0xD9 -> TX_PAR_EN=1, TX_PAR_TYP=1; the transmitter parity bit on the line is 0.
